// File: rtl/ref_read_arbiter_pkg.sv
// Shared types and defaults for the reference-read arbiter and its selector.
package ref_read_arbiter_pkg;

    // Matches the Engine's 25-bit ref address/length fields.
    localparam int REF_ADDR_WIDTH = 25;
    localparam int REF_LEN_WIDTH  = 25;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_STREAM = 2'd2
    } arb_state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ref_read_arbiter_rr_select.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_select #(
    parameter int NUM_ENGINES = 4,
    parameter int ID_WIDTH    = $clog2(NUM_ENGINES)
) (
    input  logic [NUM_ENGINES-1:0] eligible,
    input  logic [ID_WIDTH-1:0]    ptr,
    output logic                   found,
    output logic [ID_WIDTH-1:0]    idx
);

    // Walk offsets from far to near so the nearest eligible index wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
            if (eligible[(int'(ptr) + k) % NUM_ENGINES]) begin
                found = 1'b1;
                idx   = ID_WIDTH'((int'(ptr) + k) % NUM_ENGINES);
            end
        end
    end

endmodule

// File: rtl/ref_read_arbiter.sv
// Shares one DRAM reference reader among NUM_ENGINES engines with round-robin grants.
//  state     | meaning
//  ST_IDLE   | waiting for an eligible request; zero-length requests retire here
//  ST_ISSUE  | rd_info_valid_out high until the reader accepts address/length
//  ST_STREAM | reader blocks routed to the granted engine until count is exhausted
module ref_read_arbiter
    import ref_read_arbiter_pkg::*;
#(
    parameter int NUM_ENGINES = 4,
    parameter int REF_LENGTH  = 128,
    parameter int ADDR_WIDTH  = REF_ADDR_WIDTH,
    parameter int LEN_WIDTH   = REF_LEN_WIDTH,
    parameter int ID_WIDTH    = $clog2(NUM_ENGINES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_ENGINES*ADDR_WIDTH-1:0] eng_ref_addr_in,
    input  logic [NUM_ENGINES*LEN_WIDTH-1:0]  eng_ref_length_in,
    input  logic [NUM_ENGINES-1:0]            eng_ref_info_valid_in,
    output logic [2*REF_LENGTH-1:0]           eng_ref_block_out,
    output logic [NUM_ENGINES-1:0]            eng_ref_block_valid_out,
    input  logic [NUM_ENGINES-1:0]            eng_ref_block_rdy_in,
    output logic [ADDR_WIDTH-1:0]             rd_addr_out,
    output logic [LEN_WIDTH-1:0]              rd_length_out,
    output logic                              rd_info_valid_out,
    input  logic                              rd_info_rdy_in,
    input  logic [2*REF_LENGTH-1:0]           rd_block_in,
    input  logic                              rd_block_valid_in,
    output logic                              rd_block_rdy_out,
    output logic                              busy_out,
    output logic [ID_WIDTH-1:0]               grant_id_out
);

    arb_state_t                 state;
    logic [ID_WIDTH-1:0]        rr_ptr;
    logic [LEN_WIDTH-1:0]       remaining;
    logic [NUM_ENGINES-1:0]     armed;
    logic [NUM_ENGINES-1:0]     eligible;
    logic                       sel_found;
    logic [ID_WIDTH-1:0]        sel_idx;
    logic [ADDR_WIDTH-1:0]      sel_addr;
    logic [LEN_WIDTH-1:0]       sel_len;
    logic                       beat;
    logic                       txn_done;
    logic [ID_WIDTH-1:0]        done_idx;
    logic [NUM_ENGINES-1:0]     clear_mask;

    assign eligible = eng_ref_info_valid_in & armed;

    rr_select #(
        .NUM_ENGINES (NUM_ENGINES),
        .ID_WIDTH    (ID_WIDTH)
    ) u_rr_select (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .found    (sel_found),
        .idx      (sel_idx)
    );

    assign sel_addr = eng_ref_addr_in[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_len  = eng_ref_length_in[sel_idx*LEN_WIDTH +: LEN_WIDTH];

    // Routing only depends on state and grant, so engine ready never reaches block valid.
    always_comb begin
        eng_ref_block_out       = rd_block_in;
        eng_ref_block_valid_out = '0;
        rd_block_rdy_out        = 1'b0;
        if (state == ST_STREAM) begin
            eng_ref_block_valid_out[grant_id_out] = rd_block_valid_in;
            rd_block_rdy_out                      = eng_ref_block_rdy_in[grant_id_out];
        end
    end

    assign beat     = rd_block_valid_in && rd_block_rdy_out;
    assign busy_out = (state != ST_IDLE);

    always_comb begin
        txn_done   = 1'b0;
        done_idx   = '0;
        clear_mask = '0;
        if (state == ST_IDLE && sel_found && sel_len == '0) begin
            txn_done = 1'b1;
            done_idx = sel_idx;
        end else if (state == ST_STREAM && beat && remaining == LEN_WIDTH'(1)) begin
            txn_done = 1'b1;
            done_idx = grant_id_out;
        end
        if (txn_done) begin
            clear_mask[done_idx] = 1'b1;
        end
    end

    // A low request level re-arms the engine, taking precedence over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= '1;
        end else begin
            armed <= (armed & ~clear_mask) | ~eng_ref_info_valid_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            rr_ptr            <= '0;
            remaining         <= '0;
            grant_id_out      <= '0;
            rd_addr_out       <= '0;
            rd_length_out     <= '0;
            rd_info_valid_out <= 1'b0;
        end else begin
            if (txn_done) begin
                rr_ptr <= ID_WIDTH'(wrap_inc(int'(done_idx), NUM_ENGINES));
            end
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        grant_id_out  <= sel_idx;
                        rd_addr_out   <= sel_addr;
                        rd_length_out <= sel_len;
                        if (sel_len != '0) begin
                            state             <= ST_ISSUE;
                            rd_info_valid_out <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (rd_info_rdy_in) begin
                        rd_info_valid_out <= 1'b0;
                        remaining         <= rd_length_out;
                        state             <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (beat) begin
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ref_read_arbiter.sv
// Directed scoreboard bench for ref_read_arbiter: grants, routing, backpressure, re-arm, reset.
module tb_ref_read_arbiter;

    localparam int N  = 4;
    localparam int RL = 128;
    localparam int AW = 25;
    localparam int LW = 25;
    localparam int IW = 2;

    typedef struct {
        int            id;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*AW-1:0]   eng_addr;
    logic [N*LW-1:0]   eng_len;
    logic [N-1:0]      eng_valid;
    logic [2*RL-1:0]   eng_block;
    logic [N-1:0]      eng_block_valid;
    logic [N-1:0]      eng_rdy;
    logic [AW-1:0]     rd_addr;
    logic [LW-1:0]     rd_length;
    logic              rd_info_valid;
    logic              rd_info_rdy;
    logic [2*RL-1:0]   rd_block;
    logic              rd_block_valid;
    logic              rd_block_rdy;
    logic              busy;
    logic [IW-1:0]     grant_id;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ref_read_arbiter #(
        .NUM_ENGINES (N),
        .REF_LENGTH  (RL),
        .ADDR_WIDTH  (AW),
        .LEN_WIDTH   (LW),
        .ID_WIDTH    (IW)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .eng_ref_addr_in         (eng_addr),
        .eng_ref_length_in       (eng_len),
        .eng_ref_info_valid_in   (eng_valid),
        .eng_ref_block_out       (eng_block),
        .eng_ref_block_valid_out (eng_block_valid),
        .eng_ref_block_rdy_in    (eng_rdy),
        .rd_addr_out             (rd_addr),
        .rd_length_out           (rd_length),
        .rd_info_valid_out       (rd_info_valid),
        .rd_info_rdy_in          (rd_info_rdy),
        .rd_block_in             (rd_block),
        .rd_block_valid_in       (rd_block_valid),
        .rd_block_rdy_out        (rd_block_rdy),
        .busy_out                (busy),
        .grant_id_out            (grant_id)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [AW-1:0] a, input logic [LW-1:0] l);
        eng_addr[id*AW +: AW] = a;
        eng_len[id*LW +: LW]  = l;
        eng_valid[id]         = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},   256'(busy), 256'(0));
        chk({tag, "_grant"},  256'(grant_id), 256'(0));
        chk({tag, "_ivalid"}, 256'(rd_info_valid), 256'(0));
        chk({tag, "_addr"},   256'(rd_addr), 256'(0));
        chk({tag, "_len"},    256'(rd_length), 256'(0));
        chk({tag, "_brdy"},   256'(rd_block_rdy), 256'(0));
        chk({tag, "_bvalid"}, 256'(eng_block_valid), 256'(0));
    endtask

    // Services one reader transaction; stop_beats below the length leaves it mid-stream.
    task automatic serve(input string tag, input int stop_beats,
                         input logic [15:0] rdy_pat, input int pat_len);
        exp_t           e;
        int             waited;
        int             beats;
        int             k;
        logic [255:0]   data;
        logic [N-1:0]   exp_valid;
        waited = 0;
        while (!rd_info_valid && waited < 20) begin
            cyc();
            waited++;
        end
        chk({tag, "_grant_seen"}, 256'(rd_info_valid), 256'(1));
        if (!rd_info_valid) return;
        chk({tag, "_sb_size"}, 256'(sb.size() > 0), 256'(1));
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, "_grant_id"}, 256'(grant_id), 256'(e.id));
        chk({tag, "_rd_addr"},  256'(rd_addr), 256'(e.addr));
        chk({tag, "_rd_len"},   256'(rd_length), 256'(e.len));
        chk({tag, "_busy_on"},  256'(busy), 256'(1));
        rd_info_rdy = 1'b1;
        cyc();
        rd_info_rdy = 1'b0;
        chk({tag, "_ivalid_off"}, 256'(rd_info_valid), 256'(0));
        beats = 0;
        k     = 0;
        while (beats < stop_beats && k < 60) begin
            for (int w = 0; w < 8; w++) data[w*32 +: 32] = $urandom();
            rd_block       = data;
            rd_block_valid = 1'b1;
            eng_rdy        = '1;
            if (k < pat_len) eng_rdy[e.id] = rdy_pat[k];
            #1;
            exp_valid       = '0;
            exp_valid[e.id] = 1'b1;
            chk({tag, "_blk_valid"}, 256'(eng_block_valid), 256'(exp_valid));
            chk({tag, "_blk_rdy"},   256'(rd_block_rdy), 256'(eng_rdy[e.id]));
            chk({tag, "_blk_data"},  eng_block, data);
            if (eng_rdy[e.id]) beats++;
            k++;
            cyc();
        end
        chk({tag, "_beats"}, 256'(beats), 256'(stop_beats));
        eng_rdy = '1;
        if (stop_beats == int'(e.len)) begin
            // Stray reader data after the last beat must be held off.
            #1;
            chk({tag, "_busy_off"},    256'(busy), 256'(0));
            chk({tag, "_stray_rdy"},   256'(rd_block_rdy), 256'(0));
            chk({tag, "_stray_valid"}, 256'(eng_block_valid), 256'(0));
        end
        rd_block_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        eng_addr       = '0;
        eng_len        = '0;
        eng_valid      = '0;
        eng_rdy        = '1;
        rd_info_rdy    = 1'b0;
        rd_block       = '0;
        rd_block_valid = 1'b0;
        cyc();
        cyc();
        chk_reset("reset");
        rst = 1'b0;

        // 1: single request, one-cycle grant latency
        set_req(2, 25'h100, 25'd3);
        sb.push_back('{2, 25'h100, 25'd3});
        #1;
        chk("t1_no_early_valid", 256'(rd_info_valid), 256'(0));
        cyc();
        chk("t1_latency", 256'(rd_info_valid), 256'(1));
        serve("t1", 3, 16'h0, 0);
        chk("t1_grant_kept", 256'(grant_id), 256'(2));
        eng_valid[2] = 1'b0;

        // 2: contention from reset, order 0,1,3
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        set_req(0, 25'h010, 25'd2);
        set_req(1, 25'h020, 25'd2);
        set_req(3, 25'h030, 25'd2);
        sb.push_back('{0, 25'h010, 25'd2});
        sb.push_back('{1, 25'h020, 25'd2});
        sb.push_back('{3, 25'h030, 25'd2});
        serve("t2a", 2, 16'h0, 0);
        eng_valid[0] = 1'b0;
        serve("t2b", 2, 16'h0, 0);
        eng_valid[1] = 1'b0;
        serve("t2c", 2, 16'h0, 0);
        eng_valid[3] = 1'b0;

        // 3: backpressure 1,0,0,1,1,0,1 on engine 1 (bit k = cycle k)
        set_req(1, 25'h040, 25'd4);
        sb.push_back('{1, 25'h040, 25'd4});
        serve("t3", 4, 16'b101_1001, 7);
        eng_valid[1] = 1'b0;

        // 4: held-high valid is served once, re-armed by a low cycle
        set_req(0, 25'h050, 25'd1);
        sb.push_back('{0, 25'h050, 25'd1});
        serve("t4a", 1, 16'h0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t4_no_regrant", 256'({busy, rd_info_valid}), 256'(0));
            cyc();
        end
        eng_valid[0] = 1'b0;
        cyc();
        eng_valid[0] = 1'b1;
        sb.push_back('{0, 25'h050, 25'd1});
        cyc();
        chk("t4_regrant", 256'(rd_info_valid), 256'(1));
        serve("t4b", 1, 16'h0, 0);
        eng_valid[0] = 1'b0;
        cyc();

        // 5: zero-length request on engine 3 (rr pointer is 1) retires without a read
        set_req(3, 25'h0AA, 25'd0);
        set_req(0, 25'h060, 25'd2);
        sb.push_back('{0, 25'h060, 25'd2});
        cyc();
        chk("t5_zero_grant",  256'(grant_id), 256'(3));
        chk("t5_zero_ivalid", 256'(rd_info_valid), 256'(0));
        chk("t5_zero_busy",   256'(busy), 256'(0));
        cyc();
        chk("t5_next_grant",  256'(grant_id), 256'(0));
        chk("t5_next_ivalid", 256'(rd_info_valid), 256'(1));
        serve("t5", 2, 16'h0, 0);
        eng_valid[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_regrant3", 256'(busy), 256'(0));
            cyc();
        end
        eng_valid[3] = 1'b0;

        // 6: reset after 2 of 5 beats (rr pointer was 1 before reset)
        set_req(2, 25'h070, 25'd5);
        sb.push_back('{2, 25'h070, 25'd5});
        serve("t6a", 2, 16'h0, 0);
        chk("t6_midstream_busy", 256'(busy), 256'(1));
        rst       = 1'b1;
        eng_valid = '0;
        cyc();
        chk_reset("t6_reset");
        rst = 1'b0;
        set_req(0, 25'h080, 25'd1);
        set_req(1, 25'h090, 25'd1);
        sb.push_back('{0, 25'h080, 25'd1});
        sb.push_back('{1, 25'h090, 25'd1});
        serve("t6b", 1, 16'h0, 0);
        eng_valid[0] = 1'b0;
        serve("t6c", 1, 16'h0, 0);
        eng_valid[1] = 1'b0;
        chk("sb_drained", 256'(sb.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
